// File: rtl/note_hit_judge.sv
// Note hit judge: per-lane timed hit windows, strum/fret judging, score, combo and multiplier.
// Strum edge is judged 2 clocks after the input is sampled, and all outputs are registered; there is no backpressure.
module note_hit_judge #(
    parameter int WINDOW_CYCLES  = 12500000,
    parameter int HIT_POINTS     = 10,
    parameter int COMBO_PER_MULT = 10,
    parameter int MAX_MULT       = 4,
    parameter int SCORE_W        = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [4:0]         i_notes_due,
    input  logic [4:0]         i_frets,
    input  logic               i_strum,
    output logic [4:0]         o_lane_active,
    output logic               o_hit,
    output logic [4:0]         o_hit_lanes,
    output logic               o_miss,
    output logic [SCORE_W-1:0] o_score,
    output logic [7:0]         o_combo,
    output logic [2:0]         o_mult
);

    localparam logic [23:0]        WIN       = 24'(WINDOW_CYCLES);
    localparam int                 STEP_W    = $clog2(COMBO_PER_MULT + 1);
    localparam logic [STEP_W-1:0]  STEP_TOP  = STEP_W'(COMBO_PER_MULT);
    localparam logic [2:0]         MULT_TOP  = 3'(MAX_MULT);
    localparam int                 SUM_W     = SCORE_W + 33;
    localparam logic [SUM_W-1:0]   SCORE_MAX = (SUM_W'(1) << SCORE_W) - SUM_W'(1);

    logic [4:0]         r_fret_s1;
    logic [4:0]         r_fret_s2;
    logic               r_strum_s1;
    logic               r_strum_s2;
    logic               r_strum_d;
    logic [4:0]         r_notes_prev;
    logic [4:0]         r_act;
    logic [23:0]        r_cnt [5];
    logic               r_hit;
    logic [4:0]         r_hit_lanes;
    logic               r_miss;
    logic [SCORE_W-1:0] r_score;
    logic [7:0]         r_combo;
    logic [2:0]         r_mult;
    logic [STEP_W-1:0]  r_step;

    logic [4:0]         w_note_edge;
    logic               w_strum_edge;
    logic               w_hit;
    logic               w_miss;
    logic [4:0]         w_clear;
    logic [4:0]         w_expire;
    logic [4:0]         w_act_next;
    logic [2:0]         w_popcnt;
    logic [31:0]        w_add;
    logic [SUM_W-1:0]   w_sum;
    logic [STEP_W-1:0]  w_step_inc;

    // Frets only need a stable level at judge time, so they skip the edge-detect delay.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fret_s1    <= '0;
            r_fret_s2    <= '0;
            r_strum_s1   <= 1'b0;
            r_strum_s2   <= 1'b0;
            r_strum_d    <= 1'b0;
            r_notes_prev <= '0;
        end else begin
            r_fret_s1    <= i_frets;
            r_fret_s2    <= r_fret_s1;
            r_strum_s1   <= i_strum;
            r_strum_s2   <= r_strum_s1;
            r_strum_d    <= r_strum_s2;
            r_notes_prev <= i_notes_due;
        end
    end

    assign w_note_edge  = i_notes_due & ~r_notes_prev;
    assign w_strum_edge = r_strum_s2 & ~r_strum_d;
    assign w_hit        = w_strum_edge && (r_act != 5'd0) && (r_fret_s2 == r_act);
    assign w_clear      = w_hit ? r_act : 5'd0;

    // A lane re-armed by a new note this cycle is not an expiry.
    always_comb begin
        w_expire = '0;
        for (int k = 0; k < 5; k++) begin
            w_expire[k] = r_act[k] && (r_cnt[k] == 24'd1) && !w_clear[k] && !w_note_edge[k];
        end
    end

    assign w_act_next = w_note_edge | (r_act & ~w_clear & ~w_expire);
    assign w_miss     = (w_strum_edge && !w_hit) || (w_expire != 5'd0);

    always_comb begin
        w_popcnt = '0;
        for (int k = 0; k < 5; k++) begin
            w_popcnt = w_popcnt + {2'b00, r_act[k]};
        end
    end

    assign w_add      = 32'(HIT_POINTS) * {29'd0, w_popcnt} * {29'd0, r_mult};
    assign w_sum      = SUM_W'(r_score) + SUM_W'(w_add);
    assign w_step_inc = r_step + STEP_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_act <= '0;
            for (int k = 0; k < 5; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_act <= w_act_next;
            for (int k = 0; k < 5; k++) begin
                if (w_note_edge[k]) begin
                    r_cnt[k] <= WIN;
                end else if (r_act[k]) begin
                    r_cnt[k] <= r_cnt[k] - 24'd1;
                end
            end
        end
    end

    // Score uses the multiplier held before this cycle's update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hit       <= 1'b0;
            r_hit_lanes <= '0;
            r_miss      <= 1'b0;
            r_score     <= '0;
            r_combo     <= '0;
            r_mult      <= 3'd1;
            r_step      <= '0;
        end else begin
            r_hit       <= w_hit;
            r_hit_lanes <= w_clear;
            r_miss      <= w_miss;
            if (w_hit) begin
                r_score <= (w_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
                r_combo <= (r_combo == 8'hFF) ? r_combo : r_combo + 8'd1;
                if (w_step_inc == STEP_TOP) begin
                    r_step <= '0;
                    r_mult <= (r_mult == MULT_TOP) ? r_mult : r_mult + 3'd1;
                end else begin
                    r_step <= w_step_inc;
                end
            end else if (w_miss) begin
                r_combo <= '0;
                r_mult  <= 3'd1;
                r_step  <= '0;
            end
        end
    end

    assign o_lane_active = r_act;
    assign o_hit         = r_hit;
    assign o_hit_lanes   = r_hit_lanes;
    assign o_miss        = r_miss;
    assign o_score       = r_score;
    assign o_combo       = r_combo;
    assign o_mult        = r_mult;

endmodule

// File: tb/tb_note_hit_judge.sv
// Bench for note_hit_judge: directed vector table, hand-written corner sequences, and random stimulus
// checked every cycle against a deadline-based reference model.
module tb_note_hit_judge;

    localparam int W    = 8;
    localparam int HP   = 10;
    localparam int CPM  = 2;
    localparam int MAXM = 4;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] notes  = '0;
    logic [4:0] frets  = '0;
    logic       strum  = 1'b0;

    logic [4:0]  o_lane_active, o_hit_lanes, s_lane_active, s_hit_lanes;
    logic        o_hit, o_miss, s_hit, s_miss;
    logic [15:0] o_score;
    logic [5:0]  s_score;
    logic [7:0]  o_combo, s_combo;
    logic [2:0]  o_mult, s_mult;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    note_hit_judge #(.WINDOW_CYCLES(W), .HIT_POINTS(HP), .COMBO_PER_MULT(CPM),
                     .MAX_MULT(MAXM), .SCORE_W(16)) dut (
        .clk(clk), .resetn(resetn), .i_notes_due(notes), .i_frets(frets), .i_strum(strum),
        .o_lane_active(o_lane_active), .o_hit(o_hit), .o_hit_lanes(o_hit_lanes), .o_miss(o_miss),
        .o_score(o_score), .o_combo(o_combo), .o_mult(o_mult));

    note_hit_judge #(.WINDOW_CYCLES(W), .HIT_POINTS(HP), .COMBO_PER_MULT(CPM),
                     .MAX_MULT(MAXM), .SCORE_W(6)) dut_sat (
        .clk(clk), .resetn(resetn), .i_notes_due(notes), .i_frets(frets), .i_strum(strum),
        .o_lane_active(s_lane_active), .o_hit(s_hit), .o_hit_lanes(s_hit_lanes), .o_miss(s_miss),
        .o_score(s_score), .o_combo(s_combo), .o_mult(s_mult));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Arms lanes (if any), then strums with the given frets; returns on the judge-result cycle.
    task automatic strike(input logic [4:0] arm, input logic [4:0] f);
        if (arm != 5'd0) begin
            notes = arm;
            tick(1);
            notes = '0;
        end
        tick(1);
        frets = f;
        strum = 1'b1;
        tick(1);
        strum = 1'b0;
        tick(2);
    endtask

    // Reference model: open lanes carry an absolute expiry deadline; inputs reach the judge two samples late.
    int         m_cyc = 0;
    int         m_dl [5];
    logic [4:0] m_open = '0;
    int         m_score = 0, m_combo = 0, m_mult = 1, m_step = 0;
    logic       m_hit = 1'b0, m_miss = 1'b0;
    logic [4:0] m_lanes = '0;
    logic [4:0] n_prev = '0, f_h1 = '0, f_h2 = '0;
    logic [2:0] s_h = '0;
    logic [4:0] t_ne, t_exp;
    logic       t_se;

    always @(posedge clk) begin
        if (!resetn) begin
            m_open = '0; m_score = 0; m_combo = 0; m_mult = 1; m_step = 0;
            m_hit = 1'b0; m_miss = 1'b0; m_lanes = '0;
            n_prev = '0; f_h1 = '0; f_h2 = '0; s_h = '0;
        end else begin
            t_ne  = notes & ~n_prev;
            t_se  = s_h[1] & ~s_h[2];
            m_hit = t_se && (m_open != 5'd0) && (f_h2 == m_open);
            t_exp = '0;
            for (int k = 0; k < 5; k++)
                if (m_open[k] && m_dl[k] == m_cyc && !m_hit && !t_ne[k]) t_exp[k] = 1'b1;
            m_miss = (t_se && !m_hit) || (t_exp != 5'd0);
            if (m_hit) begin
                m_score += HP * $countones(m_open) * m_mult;
                m_combo = (m_combo < 255) ? m_combo + 1 : 255;
                m_step++;
                if (m_step == CPM) begin
                    m_step = 0;
                    m_mult = (m_mult < MAXM) ? m_mult + 1 : MAXM;
                end
            end else if (m_miss) begin
                m_combo = 0; m_mult = 1; m_step = 0;
            end
            m_lanes = m_hit ? m_open : 5'd0;
            m_open  = m_hit ? 5'd0 : (m_open & ~t_exp);
            for (int k = 0; k < 5; k++)
                if (t_ne[k]) begin
                    m_open[k] = 1'b1;
                    m_dl[k]   = m_cyc + W;
                end
            s_h = {s_h[1:0], strum};
            f_h2 = f_h1;
            f_h1 = frets;
            n_prev = notes;
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        if (resetn) begin
            chk("model_events", 64'({o_lane_active, o_hit, o_hit_lanes, o_miss}),
                64'({m_open, m_hit, m_lanes, m_miss}));
            chk("model_counters", 64'({o_score, o_combo, o_mult}),
                64'({16'((m_score > 65535) ? 65535 : m_score), 8'(m_combo), 3'(m_mult)}));
            chk("model_sat_score", 64'(s_score), 64'((m_score > 63) ? 63 : m_score));
        end
    end

    typedef struct {
        logic [4:0]  arm;
        logic [4:0]  frets;
        logic        hit;
        logic        miss;
        logic [4:0]  lanes;
        logic [15:0] score;
        logic [7:0]  combo;
        logic [2:0]  mult;
        logic [4:0]  active;
    } vec_t;

    vec_t tbl [7];
    int   misses;
    int   miss_at;

    initial begin
        tbl[0] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00100, 16'd10,  8'd1, 3'd1, 5'b00000};
        tbl[1] = '{5'b00000, 5'b00000, 1'b0, 1'b1, 5'b00000, 16'd10,  8'd0, 3'd1, 5'b00000};
        tbl[2] = '{5'b10001, 5'b10001, 1'b1, 1'b0, 5'b10001, 16'd30,  8'd1, 3'd1, 5'b00000};
        tbl[3] = '{5'b10001, 5'b10001, 1'b1, 1'b0, 5'b10001, 16'd50,  8'd2, 3'd2, 5'b00000};
        tbl[4] = '{5'b10001, 5'b10001, 1'b1, 1'b0, 5'b10001, 16'd90,  8'd3, 3'd2, 5'b00000};
        tbl[5] = '{5'b00010, 5'b00011, 1'b0, 1'b1, 5'b00000, 16'd90,  8'd0, 3'd1, 5'b00010};
        tbl[6] = '{5'b00000, 5'b00010, 1'b1, 1'b0, 5'b00010, 16'd100, 8'd1, 3'd1, 5'b00000};

        tick(2);
        chk("rst_active", 64'(o_lane_active), 64'd0);
        chk("rst_hit",    64'({o_hit, o_hit_lanes, o_miss}), 64'd0);
        chk("rst_score",  64'(o_score), 64'd0);
        chk("rst_combo",  64'(o_combo), 64'd0);
        chk("rst_mult",   64'(o_mult), 64'd1);
        resetn = 1'b1;
        tick(1);

        for (int i = 0; i < 7; i++) begin
            strike(tbl[i].arm, tbl[i].frets);
            chk($sformatf("vec%0d_hit", i),    64'(o_hit), 64'(tbl[i].hit));
            chk($sformatf("vec%0d_miss", i),   64'(o_miss), 64'(tbl[i].miss));
            chk($sformatf("vec%0d_lanes", i),  64'(o_hit_lanes), 64'(tbl[i].lanes));
            chk($sformatf("vec%0d_score", i),  64'(o_score), 64'(tbl[i].score));
            chk($sformatf("vec%0d_combo", i),  64'(o_combo), 64'(tbl[i].combo));
            chk($sformatf("vec%0d_mult", i),   64'(o_mult), 64'(tbl[i].mult));
            chk($sformatf("vec%0d_active", i), 64'(o_lane_active), 64'(tbl[i].active));
        end

        // Reset while a window is open: everything clears and no miss follows.
        notes = 5'b00001; tick(1); notes = '0;
        tick(2);
        chk("midrst_pre_active", 64'(o_lane_active), 64'b00001);
        resetn = 1'b0;
        tick(1);
        chk("midrst_active", 64'(o_lane_active), 64'd0);
        chk("midrst_score",  64'(o_score), 64'd0);
        chk("midrst_mult",   64'(o_mult), 64'd1);
        resetn = 1'b1;
        misses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (o_miss) misses++;
        end
        chk("midrst_no_miss", 64'(misses), 64'd0);

        // Two-lane expiry after a hit: a single miss exactly W cycles after arming.
        strike(5'b00001, 5'b00001);
        chk("exp_pre_combo", 64'(o_combo), 64'd1);
        notes = 5'b01010; tick(1); notes = '0;
        misses = 0;
        miss_at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (o_miss) begin
                misses++;
                miss_at = i;
            end
        end
        chk("exp_miss_count", 64'(misses), 64'd1);
        chk("exp_miss_cycle", 64'(miss_at), 64'(W));
        chk("exp_active",     64'(o_lane_active), 64'd0);
        chk("exp_combo",      64'(o_combo), 64'd0);
        chk("exp_mult",       64'(o_mult), 64'd1);

        // Hit on lane 0 with a new lane-0 note landing on the judge edge.
        notes = 5'b00001; tick(1); notes = '0;
        tick(1);
        frets = 5'b00001; strum = 1'b1;
        tick(1);
        strum = 1'b0;
        tick(1);
        notes = 5'b00001;
        tick(1);
        notes = '0;
        chk("rearm_hit",    64'(o_hit), 64'd1);
        chk("rearm_lanes",  64'(o_hit_lanes), 64'b00001);
        chk("rearm_active", 64'(o_lane_active), 64'b00001);
        strike(5'b00000, 5'b00001);
        chk("rearm_hit2",   64'(o_hit), 64'd1);
        chk("rearm_combo",  64'(o_combo), 64'd2);
        chk("rearm_mult",   64'(o_mult), 64'd2);
        chk("rearm_score",  64'(o_score), 64'd30);
        strike(5'b00000, 5'b00000);
        chk("over_miss",    64'(o_miss), 64'd1);
        chk("over_combo",   64'(o_combo), 64'd0);
        chk("over_mult",    64'(o_mult), 64'd1);

        // Five-lane chords push the 6-bit score past its ceiling.
        strike(5'b11111, 5'b11111);
        chk("sat1_score16", 64'(o_score), 64'd80);
        chk("sat1_score6",  64'(s_score), 64'd63);
        strike(5'b11111, 5'b11111);
        chk("sat2_score16", 64'(o_score), 64'd130);
        chk("sat2_score6",  64'(s_score), 64'd63);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) notes = 5'($urandom) & 5'($urandom);
            if ($urandom_range(0, 4) == 0) strum = ~strum;
            frets = ($urandom_range(0, 1) == 1) ? m_open : 5'($urandom);
            tick(1);
        end
        notes = '0;
        strum = 1'b0;
        tick(W + 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
